tictactoe_board_ctrl: RTL and testbench

- Owns the registered game board and consumes the one-hot move vectors that the O-strategy blocks produce. It also consumes the X player's moves.
- Validates each move, commits it to the xin/oin board registers and alternates turns.
- Detects win and draw and holds the final board until a restart.
- Its xin/oin outputs are the board vectors that feed the strategy logic.

---
 rtl/tictactoe_pkg.sv | 26 ++
 rtl/tictactoe_board_ctrl_if.sv | 16 +
 rtl/tictactoe_board_ctrl_win_detect.sv | 17 +
 rtl/tictactoe_board_ctrl.sv | 110 +++++++++++
 tb/tb_tictactoe_board_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// Squares are numbered 0..8 row-major; a board is a 9-bit occupancy vector.
package tictactoe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    X_TURN,
    O_TURN,
    X_WIN,
    O_WIN,
    DRAW
  } state_t;

  localparam int NUM_SQ = 9;

  localparam logic [7:0][NUM_SQ-1:0] WIN_LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_X    = 2'b01;
  localparam logic [1:0] WINNER_O    = 2'b10;

endpackage

// File: rtl/tictactoe_board_ctrl_if.sv
// Move handshake between the players and the board controller: one-hot moves
// with a valid, and a per-player request telling whose turn it is.
interface tictactoe_board_ctrl_if;
  import tictactoe_pkg::*;

  logic [NUM_SQ-1:0] x_move;
  logic              x_valid;
  logic [NUM_SQ-1:0] o_move;
  logic              o_valid;
  logic              x_req;
  logic              o_req;

  modport master (output x_move, x_valid, o_move, o_valid, input x_req, o_req);
  modport slave  (input x_move, x_valid, o_move, o_valid, output x_req, o_req);

endinterface

// File: rtl/tictactoe_board_ctrl_win_detect.sv
// Combinational: flags an occupancy vector that covers any complete line.
// Zero latency; no flow control.
module win_detect
  import tictactoe_pkg::*;
(
  input  logic [NUM_SQ-1:0] occ,
  output logic              win
);

  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((occ & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Board register, move validation, turn sequencing and win/draw detection.
// Moves land one cycle after the valid edge; a player waits on its req, and a bad move pulses illegal.
module tictactoe_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter bit X_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  tictactoe_board_ctrl_if.slave  mv,
  output logic [NUM_SQ-1:0]      xin,
  output logic [NUM_SQ-1:0]      oin,
  output logic [3:0]             move_count,
  output logic                   illegal,
  output logic [1:0]             winner,
  output logic                   game_over
);

  state_t            state, state_nxt;
  logic [NUM_SQ-1:0] xin_nxt, oin_nxt;
  logic [3:0]        count_nxt;
  logic [1:0]        winner_nxt;
  logic              illegal_nxt;

  logic [NUM_SQ-1:0] act_move;
  logic              act_vld;
  logic              onehot;
  logic              legal;
  logic [NUM_SQ-1:0] xin_mv, oin_mv;
  logic              x_win, o_win;

  // Only the player whose turn it is gets looked at; the other valid is dropped.
  assign act_move = (state == X_TURN) ? mv.x_move : mv.o_move;
  assign act_vld  = ((state == X_TURN) && mv.x_valid) || ((state == O_TURN) && mv.o_valid);
  assign onehot   = (act_move != '0) && ((act_move & (act_move - 9'd1)) == '0);
  assign legal    = onehot && ((act_move & (xin | oin)) == '0);
  assign xin_mv   = xin | act_move;
  assign oin_mv   = oin | act_move;

  win_detect u_x_win (.occ(xin_mv), .win(x_win));
  win_detect u_o_win (.occ(oin_mv), .win(o_win));

  always_comb begin
    state_nxt   = state;
    xin_nxt     = xin;
    oin_nxt     = oin;
    count_nxt   = move_count;
    winner_nxt  = winner;
    illegal_nxt = 1'b0;
    if (start) begin
      xin_nxt    = '0;
      oin_nxt    = '0;
      count_nxt  = 4'd0;
      winner_nxt = WINNER_NONE;
      state_nxt  = X_FIRST ? X_TURN : O_TURN;
    end else if (act_vld) begin
      if (legal) begin
        count_nxt = move_count + 4'd1;
        // A completed line beats a full board, so a 9th-move win is a win.
        if (state == X_TURN) begin
          xin_nxt = xin_mv;
          if (x_win) begin
            state_nxt  = X_WIN;
            winner_nxt = WINNER_X;
          end else if (move_count == 4'd8) begin
            state_nxt = DRAW;
          end else begin
            state_nxt = O_TURN;
          end
        end else begin
          oin_nxt = oin_mv;
          if (o_win) begin
            state_nxt  = O_WIN;
            winner_nxt = WINNER_O;
          end else if (move_count == 4'd8) begin
            state_nxt = DRAW;
          end else begin
            state_nxt = X_TURN;
          end
        end
      end else begin
        illegal_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      xin        <= '0;
      oin        <= '0;
      move_count <= 4'd0;
      winner     <= WINNER_NONE;
      illegal    <= 1'b0;
    end else begin
      state      <= state_nxt;
      xin        <= xin_nxt;
      oin        <= oin_nxt;
      move_count <= count_nxt;
      winner     <= winner_nxt;
      illegal    <= illegal_nxt;
    end
  end

  assign mv.x_req  = (state == X_TURN);
  assign mv.o_req  = (state == O_TURN);
  assign game_over = (state == X_WIN) || (state == O_WIN) || (state == DRAW);

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed bench: a square-by-square game model is checked against the DUT every cycle,
// with literal expectations from hand-played games pinning the model.
module tb_tictactoe_board_ctrl;

  localparam bit X_FIRST = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] xin, oin;
  logic [3:0] move_count;
  logic       illegal;
  logic [1:0] winner;
  logic       game_over;

  tictactoe_board_ctrl_if bus ();

  tictactoe_board_ctrl #(.X_FIRST(X_FIRST)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mv         (bus.slave),
    .xin        (xin),
    .oin        (oin),
    .move_count (move_count),
    .illegal    (illegal),
    .winner     (winner),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: cell contents 0 empty / 1 X / 2 O, whose turn (0 none), and result.
  int m_cell [9];
  int m_turn;
  int m_result;   // 0 playing or idle, 1 X won, 2 O won, 3 draw
  int m_count;
  bit m_illegal;

  function automatic bit line_won(int p);
    bit w = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (m_cell[3*r] == p && m_cell[3*r+1] == p && m_cell[3*r+2] == p) w = 1'b1;
      if (m_cell[r] == p && m_cell[r+3] == p && m_cell[r+6] == p) w = 1'b1;
    end
    if (m_cell[0] == p && m_cell[4] == p && m_cell[8] == p) w = 1'b1;
    if (m_cell[2] == p && m_cell[4] == p && m_cell[6] == p) w = 1'b1;
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_count  = 0;
    m_result = 0;
  endtask

  task automatic model_step();
    logic [8:0] v;
    bit         vv;
    int         ones, sq;
    m_illegal = 1'b0;
    if (start) begin
      model_clear();
      m_turn = X_FIRST ? 1 : 2;
    end else if (m_turn != 0) begin
      v  = (m_turn == 1) ? bus.x_move : bus.o_move;
      vv = (m_turn == 1) ? bus.x_valid : bus.o_valid;
      if (vv) begin
        ones = 0;
        sq   = 0;
        for (int i = 0; i < 9; i++) if (v[i]) begin ones++; sq = i; end
        if (ones == 1 && m_cell[sq] == 0) begin
          m_cell[sq] = m_turn;
          m_count++;
          if (line_won(m_turn)) begin m_result = m_turn; m_turn = 0; end
          else if (m_count == 9) begin m_result = 3; m_turn = 0; end
          else m_turn = 3 - m_turn;
        end else begin
          m_illegal = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
      m_turn    = 0;
      m_illegal = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    logic [8:0] ex, eo;
    logic [1:0] ew;
    if (cmp_en) begin
      ex = '0;
      eo = '0;
      for (int i = 0; i < 9; i++) begin
        ex[i] = (m_cell[i] == 1);
        eo[i] = (m_cell[i] == 2);
      end
      ew = (m_result == 1) ? 2'b01 : (m_result == 2) ? 2'b10 : 2'b00;
      n_cmp++;
      if ({xin, oin, bus.x_req, bus.o_req, move_count, illegal, winner, game_over} !==
          {ex, eo, m_turn == 1, m_turn == 2, m_count[3:0], m_illegal, ew, m_result != 0}) begin
        n_bad++;
        $display("FAIL model t=%0t got xin=%h oin=%h xreq=%b oreq=%b cnt=%0d ill=%b win=%b over=%b want xin=%h oin=%h xreq=%b oreq=%b cnt=%0d ill=%b win=%b over=%b",
                 $time, xin, oin, bus.x_req, bus.o_req, move_count, illegal, winner, game_over,
                 ex, eo, m_turn == 1, m_turn == 2, m_count, m_illegal, ew, m_result != 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return to idle inputs; ends just after the committing edge.
  task automatic cyc(input logic st, input logic xv, input logic [8:0] xm,
                     input logic ov, input logic [8:0] om);
    @(negedge clk);
    start = st; bus.x_valid = xv; bus.x_move = xm; bus.o_valid = ov; bus.o_move = om;
    @(negedge clk);
    start = 1'b0; bus.x_valid = 1'b0; bus.x_move = '0; bus.o_valid = 1'b0; bus.o_move = '0;
  endtask

  task automatic xm(input int sq);
    cyc(1'b0, 1'b1, 9'h001 << sq, 1'b0, 9'h000);
  endtask

  task automatic om(input int sq);
    cyc(1'b0, 1'b0, 9'h000, 1'b1, 9'h001 << sq);
  endtask

  task automatic new_game();
    cyc(1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
  endtask

  initial begin
    bus.x_move = '0; bus.x_valid = 1'b0; bus.o_move = '0; bus.o_valid = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_xin", xin, 0);
    chk("reset_idle_xreq", bus.x_req, 0);
    reset = 1'b0;
    xm(4);
    chk("idle_ignores_move", {illegal, xin}, 0);

    new_game();
    chk("start_xreq", bus.x_req, 1);
    chk("start_cnt", move_count, 0);

    xm(4); om(0);
    chk("two_moves_board", {xin, oin}, {9'h010, 9'h001});
    chk("two_moves_cnt", move_count, 2);
    chk("two_moves_xreq", bus.x_req, 1);

    xm(0);
    chk("occupied_illegal", illegal, 1);
    chk("occupied_board", xin, 9'h010);
    cyc(1'b0, 1'b1, 9'h003, 1'b0, 9'h000);
    chk("multihot_illegal", illegal, 1);
    cyc(1'b0, 1'b1, 9'h000, 1'b0, 9'h000);
    chk("zero_illegal", illegal, 1);
    om(2);
    chk("inactive_o_ignored", {illegal, oin, bus.x_req}, {1'b0, 9'h001, 1'b1});
    cyc(1'b0, 1'b1, 9'h002, 1'b1, 9'h004);
    chk("both_valid_x_only", {xin, oin, bus.o_req}, {9'h012, 9'h001, 1'b1});

    new_game();
    xm(0); om(3); xm(1); om(4); xm(2);
    chk("xwin_board", xin, 9'h007);
    chk("xwin_result", {winner, game_over}, {2'b01, 1'b1});
    cyc(1'b0, 1'b1, 9'h100, 1'b1, 9'h080);
    chk("terminal_ignores", {xin, oin, illegal}, {9'h007, 9'h018, 1'b0});

    new_game();
    xm(0); om(3); xm(1); om(4); xm(8); om(5);
    chk("owin_result", {oin, winner, game_over}, {9'h038, 2'b10, 1'b1});

    new_game();
    xm(4); om(0); xm(2); om(6); xm(3); om(5); xm(1); om(7); xm(8);
    chk("draw_board", {xin, oin}, {9'h11E, 9'h0E1});
    chk("draw_result", {move_count, winner, game_over}, {4'd9, 2'b00, 1'b1});
    new_game();
    chk("restart_after_draw", {xin, oin, bus.x_req}, {9'h000, 9'h000, 1'b1});

    xm(0); om(1); xm(2); om(3); xm(5); om(4); xm(7); om(6); xm(8);
    chk("ninth_move_win", {xin, oin, move_count, winner}, {9'h1A5, 9'h05A, 4'd9, 2'b01});

    new_game();
    xm(0);
    cyc(1'b1, 1'b1, 9'h002, 1'b0, 9'h000);
    chk("start_beats_move", {xin, move_count, bus.x_req}, {9'h000, 4'd0, 1'b1});

    xm(4);
    @(negedge clk);
    bus.o_valid = 1'b1; bus.o_move = 9'h001;
    #2 reset = 1'b1;
    #1 chk("async_reset", {xin, oin, move_count, winner, bus.x_req, bus.o_req}, 0);
    @(negedge clk);
    bus.o_valid = 1'b0; bus.o_move = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {bus.x_req, bus.o_req, game_over}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
